// File: rtl/module_arbitro_rr3.sv
// Three-way round-robin arbiter driving the select of a shared 3:1 mux.
// A hold timer pre-empts an owner that keeps its request while others wait.
module module_arbitro_rr3 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

    state_t        r_state, w_state_n;
    logic [1:0]    r_owner, w_owner_n;
    logic [1:0]    r_last, w_last_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_gnt, w_gnt_n;
    logic [1:0]    r_sel, w_sel_n;
    logic          r_timeout, w_timeout_n;

    logic [2:0]    w_any;
    logic [2:0]    w_oth;
    logic          w_own_req;

    function automatic logic f_bit(input logic [2:0] req, input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = req[0];
            2'd1:    b = req[1];
            2'd2:    b = req[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Returns {found, index}; candidates are last+1, last+2, last (mod 3).
    function automatic logic [2:0] f_search(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c;
        logic [2:0] res;
        res = 3'b000;
        c   = last;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!res[2] && f_bit(req, c)) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign w_own_req = f_bit(req_i, r_owner);
    assign w_any     = f_search(r_last, req_i);
    assign w_oth     = f_search(r_last, req_i & ~f_onehot(r_owner));

    always_comb begin
        w_state_n   = r_state;
        w_owner_n   = r_owner;
        w_last_n    = r_last;
        w_cnt_n     = r_cnt;
        w_gnt_n     = r_gnt;
        w_sel_n     = r_sel;
        w_timeout_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any[2]) begin
                    w_state_n = GRANT;
                    w_owner_n = w_any[1:0];
                    w_last_n  = w_any[1:0];
                    w_sel_n   = w_any[1:0];
                    w_gnt_n   = f_onehot(w_any[1:0]);
                    w_cnt_n   = CW'(1);
                end
            end
            GRANT: begin
                if (!w_own_req || r_cnt == MAXC) begin
                    if (w_oth[2]) begin
                        w_owner_n   = w_oth[1:0];
                        w_last_n    = w_oth[1:0];
                        w_sel_n     = w_oth[1:0];
                        w_gnt_n     = f_onehot(w_oth[1:0]);
                        w_cnt_n     = CW'(1);
                        w_timeout_n = w_own_req;
                    end else if (!w_own_req) begin
                        // sel keeps its value so the mux output stays stable while idle
                        w_state_n = IDLE;
                        w_gnt_n   = 3'b000;
                    end else begin
                        w_cnt_n = CW'(1);
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd2;
            r_cnt     <= '0;
            r_gnt     <= 3'b000;
            r_sel     <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_owner   <= w_owner_n;
            r_last    <= w_last_n;
            r_cnt     <= w_cnt_n;
            r_gnt     <= w_gnt_n;
            r_sel     <= w_sel_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign gnt_o     = r_gnt;
    assign sel_o     = r_sel;
    assign busy_o    = |r_gnt;
    assign timeout_o = r_timeout;

endmodule

// File: doc/module_arbitro_rr3.md
# module_arbitro_rr3

Round-robin arbiter that shares one 3:1 result multiplexer (and the resource behind it) between three requesters. It registers a one-hot grant and drives the 2-bit select of the downstream 3-to-1 mux with the matching code. A hold timer stops any single owner from monopolising the resource. The block is purely control: no data passes through it.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one owner keeps the grant while others wait; legal range 2..255.
- CW, default $clog2(MAX_HOLD+1): hold-counter width; derived, not overridden.

- clk_i  input  1  single system clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  3  request per requester; bit k = requester k; level-sensitive, held until done.
- gnt_o  output  3  registered one-hot grant; 000 when idle.
- sel_o  output  2  mux select: 00 = requester 0, 01 = requester 1, 10 = requester 2; never 11.
- busy_o  output  1  high whenever gnt_o != 000.
- timeout_o  output  1  one-cycle pulse when a grant is pre-empted by the hold timer.

## Operation
- Registered state: owner (2 bits), last (2 bits, last granted index), hold_cnt (CW bits), state in {IDLE, GRANT}.
- Reset: state IDLE, gnt_o 000, sel_o 00, busy_o 0, timeout_o 0, hold_cnt 0, last = 2, so requester 0 has first priority.
- Priority search: candidates in order last+1, last+2, last (mod 3); the first candidate with req high wins.
- IDLE: if req_i == 000, stay. Otherwise grant the search winner. Set gnt_o one-hot, sel_o = winner index, owner = last = winner, hold_cnt = 1, and go to GRANT.
- GRANT, release (req_i[owner] == 0 at the edge):
  - Re-run the search with the owner excluded.
  - If a winner exists, grant it at the same edge with no idle bubble, and set hold_cnt = 1.
  - If none exists, go to IDLE with gnt_o 000. sel_o holds its last value so the mux output stays stable.
- GRANT, continue: if req_i[owner] == 1 and hold_cnt < MAX_HOLD, keep the grant and increment hold_cnt.
- GRANT, pre-empt: if req_i[owner] == 1 and hold_cnt == MAX_HOLD:
  - If any other requester is high, grant the search winner with the owner excluded, set hold_cnt = 1, and pulse timeout_o.
  - If no other requester is high, the owner keeps the grant, hold_cnt reloads to 1, and timeout_o stays 0.
- Requests that are not the owner never change the grant in GRANT state until release or pre-emption.
- sel_o and gnt_o always update on the same edge and always agree while busy_o = 1.
- hold_cnt saturates logic: it never exceeds MAX_HOLD and never wraps.

## Timing
- Grant latency: req_i sampled at edge n in IDLE gives gnt_o and sel_o valid from edge n (visible in cycle n+1). Minimum latency is 1 cycle.
- Handover latency is 0 bubble cycles: release and new grant happen on the same edge.
- Maximum wait for any continuously requesting requester is 2*MAX_HOLD cycles after its request is first sampled.
- timeout_o is high for exactly the one cycle following the pre-empting edge.
- Reset has priority over every other event, including mid-grant. Asserting rst_i at any edge forces all reset values on that edge, regardless of req_i.
- Simultaneous events:
  - Release and timeout on the same edge are treated as a release; timeout_o stays 0.
  - Requests arriving on the handover edge are eligible in that edge's search.
- All outputs come directly from registers; there is no combinational path from req_i to any output.

## Test plan
- Reset: hold rst_i 3 cycles with req_i = 111. Required: gnt_o = 000, sel_o = 00, busy_o = 0, timeout_o = 0. After release, the first grant goes to requester 0 (gnt 001, sel 00).
- Single requester: req_i = 010 for 5 cycles, then 000. Required: gnt 010 and sel 01 one cycle after the request. gnt returns to 000 one cycle after the drop, and sel stays 01.
- Round robin: all three request, and each drops its request 3 cycles after being granted. Required: grant order 0, 1, 2 with zero-cycle gaps (gnt 001, 010, 100; sel 00, 01, 10). After the last drop, busy_o falls.
- Pre-emption (MAX_HOLD = 4): req_i = 011 held. Required: requester 0 holds for exactly 4 cycles, timeout_o pulses once, then requester 1 gets 4 cycles. The pattern alternates indefinitely.
- Lone owner (MAX_HOLD = 4): req_i = 100 held for 20 cycles. Required: gnt stays 100 throughout, and timeout_o never asserts.
- Reset mid-grant: requester 2 is granted with hold_cnt = 3, then rst_i is pulsed for 1 cycle with req_i = 110. Required: reset values appear the cycle after the pulse, and the next grant goes to requester 1 (last = 2 after reset).
